// File: rtl/axi_master_tg.sv
// axi_master_tg: self-checking AXI4 traffic generator.
// Writes an address-derived pattern across a 2^A_WIDTH_TEST byte window in
// fixed-length INCR bursts, reads the window back and checks every beat.
// The pattern is inverted on every other pass.
// Optional feature macro: AXI_MASTER_RREADY_THROTTLE_EN. When it is defined,
// rready/bready are forced low one cycle in four to exercise slave backpressure.
module axi_master_tg #(
  parameter int         A_WIDTH_TEST = 12,
  parameter int         A_WIDTH      = 26,
  parameter int         D_WIDTH      = 16,
  parameter int         D_LEVEL      = 1,
  parameter logic [7:0] WBURST_LEN   = 8'd7,
  parameter logic [7:0] RBURST_LEN   = 8'd7
) (
  input  logic               rstn,
  input  logic               clk,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  input  logic               arready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  input  logic               rvalid,
  output logic               rready,
  input  logic               rlast,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               error,
  output logic [15:0]        error_cnt
);

  typedef enum logic [2:0] {S_AW, S_W, S_B, S_AR, S_R} state_t;

  // Burst strides in bytes; the cast wraps a window-sized burst to 0 so the
  // sweep then ends after a single burst.
  localparam int                    W_BYTES = (int'(WBURST_LEN) + 1) << D_LEVEL;
  localparam int                    R_BYTES = (int'(RBURST_LEN) + 1) << D_LEVEL;
  localparam logic [A_WIDTH_TEST-1:0] W_STEP = A_WIDTH_TEST'(W_BYTES);
  localparam logic [A_WIDTH_TEST-1:0] R_STEP = A_WIDTH_TEST'(R_BYTES);
  localparam int P_WIDTH = (A_WIDTH_TEST > D_WIDTH) ? A_WIDTH_TEST : D_WIDTH;

  state_t                  r_state;
  logic [A_WIDTH_TEST-1:0] r_waddr;
  logic [A_WIDTH_TEST-1:0] r_raddr;
  logic [7:0]              r_beat;
  logic                    r_pass;      // only the pass parity shapes the pattern
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_wlast;
  logic [D_WIDTH-1:0]      r_wdata;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_error;
  logic [15:0]             r_error_cnt;

  logic                    w_bready;
  logic                    w_rready;
  logic [7:0]              w_wbeat_next;
  logic [A_WIDTH_TEST-1:0] w_wnext_addr;
  logic [A_WIDTH_TEST-1:0] w_rbeat_addr;
  logic [A_WIDTH_TEST-1:0] w_waddr_nxt;
  logic [A_WIDTH_TEST-1:0] w_raddr_nxt;
  logic [D_WIDTH-1:0]      w_rexp;
  logic                    w_rfail;

  // Pattern: beat address zero-extended or truncated to D_WIDTH, inverted on odd passes.
  function automatic logic [D_WIDTH-1:0] pattern(input logic [A_WIDTH_TEST-1:0] a,
                                                 input logic inv);
    logic [P_WIDTH-1:0] ext;
    ext = P_WIDTH'(a);
    return ext[D_WIDTH-1:0] ^ {D_WIDTH{inv}};
  endfunction

  assign w_wbeat_next = r_beat + 8'd1;
  assign w_wnext_addr = r_waddr + (A_WIDTH_TEST'(w_wbeat_next) << D_LEVEL);
  assign w_rbeat_addr = r_raddr + (A_WIDTH_TEST'(r_beat) << D_LEVEL);
  assign w_waddr_nxt  = r_waddr + W_STEP;
  assign w_raddr_nxt  = r_raddr + R_STEP;
  assign w_rexp       = pattern(w_rbeat_addr, r_pass);
  // A beat fails on a data mismatch or on rlast landing on the wrong beat.
  assign w_rfail      = (rdata != w_rexp) || (rlast != (r_beat == RBURST_LEN));

`ifdef AXI_MASTER_RREADY_THROTTLE_EN
  logic [1:0] r_thr;

  // Free-running phase counter that masks the response readies once every four cycles.
  always_ff @(posedge clk) begin
    if (!rstn) r_thr <= 2'd0;
    else       r_thr <= r_thr + 2'd1;
  end

  assign w_bready = r_bready & (r_thr != 2'd3);
  assign w_rready = r_rready & (r_thr != 2'd3);
`else
  assign w_bready = r_bready;
  assign w_rready = r_rready;
`endif

  // Single FSM: sequences the write and read sweeps and checks the read beats.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking assignment would leak new values into later lines.
    if (!rstn) begin
      r_state     <= S_AW;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_beat      <= 8'd0;
      r_pass      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_error     <= 1'b0;
      r_error_cnt <= 16'd0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_AW: begin
          if (!r_awvalid) begin
            r_awvalid <= 1'b1;                 // first burst after reset
          end else if (awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wdata   <= pattern(r_waddr, r_pass);
            r_wlast   <= (WBURST_LEN == 8'd0);
            r_beat    <= 8'd0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (r_wvalid && wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_beat  <= w_wbeat_next;
              r_wdata <= pattern(w_wnext_addr, r_pass);
              r_wlast <= (w_wbeat_next == WBURST_LEN);
            end
          end
        end
        S_B: begin
          if (bvalid && w_bready) begin
            r_bready <= 1'b0;
            r_waddr  <= w_waddr_nxt;
            if (w_waddr_nxt == '0) begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end else begin
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end
          end
        end
        S_AR: begin
          if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= 8'd0;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid && w_rready) begin
            if (w_rfail) begin
              r_error <= 1'b1;
              if (r_error_cnt != 16'hFFFF) r_error_cnt <= r_error_cnt + 16'd1;
            end
            if (rlast) begin
              r_rready <= 1'b0;
              r_raddr  <= w_raddr_nxt;
              if (w_raddr_nxt == '0) begin
                r_pass    <= ~r_pass;
                r_awvalid <= 1'b1;
                r_state   <= S_AW;
              end else begin
                r_arvalid <= 1'b1;
                r_state   <= S_AR;
              end
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= S_AW;
      endcase
    end
  end

  assign awvalid   = r_awvalid;
  assign awaddr    = A_WIDTH'(r_waddr);
  assign awlen     = WBURST_LEN;
  assign wvalid    = r_wvalid;
  assign wlast     = r_wlast;
  assign wdata     = r_wdata;
  assign bready    = w_bready;
  assign arvalid   = r_arvalid;
  assign araddr    = A_WIDTH'(r_raddr);
  assign arlen     = RBURST_LEN;
  assign rready    = w_rready;
  assign error     = r_error;
  assign error_cnt = r_error_cnt;

endmodule

// File: tb/tb_axi_master_tg.sv
// tb_axi_master_tg: directed bench for axi_master_tg with a behavioural AXI
// memory slave that can corrupt one read beat, raise rlast early, and stall awready.
module tb_axi_master_tg;

  logic        clk = 1'b0;
  logic        rstn;
  logic        awvalid, awready;
  logic [25:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready, wlast;
  logic [15:0] wdata;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [25:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready, rlast;
  logic [15:0] rdata;
  logic        error;
  logic [15:0] error_cnt;

  always #5 clk = ~clk;

  axi_master_tg dut (
    .rstn(rstn), .clk(clk),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .error(error), .error_cnt(error_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave controls and state
  bit          aw_block, corrupt_arm, early_arm;
  logic [15:0] mem [0:2047];
  int          s_waddr, s_raddr, s_rcnt;
  bit          s_bpend, s_ractive;
  bit          cur_bad, cur_early;
  logic [15:0] cur_xor;

  // Monitor state
  bit          aw_f, w_f, b_f, ar_f, r_f;
  logic [25:0] awaddr_s, araddr_s;
  logic [15:0] wdata_s;
  logic        wlast_s, rlast_s;
  bit          pend_err, pend_exit, pv_stall, exit_seen, m_ar_seen;
  logic [25:0] pv_addr;
  logic [25:0] first_araddr;
  int          m_sweeps, m_wbase, m_wbeat, n_aw_sweep1, n_w_total, n_err_pulses;
  logic [15:0] exp_w;
  logic [15:0] cap20_d [8];
  logic        cap20_l [8];
  logic [15:0] cap26;
  logic [15:0] exp20 [8] = '{16'h0020, 16'h0022, 16'h0024, 16'h0026,
                             16'h0028, 16'h002A, 16'h002C, 16'h002E};

  // Slave + monitor: observe at negedge, act just after the following posedge.
  initial begin
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (pend_err || error) check("error_pulse", 32'(error), 32'(pend_err));
      if (error) n_err_pulses++;
      if (pend_exit) begin
        check("early_rlast_exit", 32'(arvalid | awvalid), 32'd1);
        exit_seen = 1'b1;
      end
      if (pv_stall) begin
        check("aw_hold_valid", 32'(awvalid), 32'd1);
        check("aw_hold_addr", 32'(awaddr), 32'(pv_addr));
      end
      pv_stall = awvalid && !awready;
      pv_addr  = awaddr;

      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      awaddr_s = awaddr; araddr_s = araddr; wdata_s = wdata; wlast_s = wlast; rlast_s = rlast;
      pend_err  = r_f && cur_bad;
      pend_exit = r_f && cur_early;

      if (aw_f) begin
        if (awaddr == 26'd0) m_sweeps++;
        if (!m_ar_seen) n_aw_sweep1++;
        m_wbase = int'(awaddr);
        m_wbeat = 0;
      end
      if (w_f) begin
        exp_w = 16'((m_wbase + 2 * m_wbeat) % 4096) ^ ((m_sweeps % 2 == 0) ? 16'hFFFF : 16'h0000);
        check("wdata", 32'(wdata), 32'(exp_w));
        check("wlast", 32'(wlast), 32'(m_wbeat == 7));
        if (m_sweeps == 1 && m_wbase == 32 && m_wbeat < 8) begin
          cap20_d[m_wbeat] = wdata;
          cap20_l[m_wbeat] = wlast;
        end
        if (m_sweeps == 2 && m_wbase + 2 * m_wbeat == 'h26) cap26 = wdata;
        n_w_total++;
        m_wbeat++;
      end
      if (ar_f && !m_ar_seen) begin
        m_ar_seen    = 1'b1;
        first_araddr = araddr;
      end

      @(posedge clk);
      #1;
      if (!rstn) begin
        s_bpend = 1'b0; s_ractive = 1'b0; cur_bad = 1'b0; cur_early = 1'b0;
        pend_err = 1'b0; pend_exit = 1'b0; pv_stall = 1'b0; m_sweeps = 0;
      end else begin
        if (aw_f) s_waddr = int'(awaddr_s);
        if (w_f) begin
          mem[(s_waddr % 4096) / 2] = wdata_s;
          s_waddr += 2;
          if (wlast_s) s_bpend = 1'b1;
        end
        if (b_f) s_bpend = 1'b0;
        if (r_f) begin
          if (rlast_s) s_ractive = 1'b0;
          else         s_rcnt++;
        end
        if (ar_f) begin
          s_raddr = int'(araddr_s); s_rcnt = 0; s_ractive = 1'b1;
        end
        if (s_ractive && (ar_f || r_f)) begin
          cur_bad = 1'b0; cur_early = 1'b0; cur_xor = 16'h0;
          if (corrupt_arm) begin
            cur_xor = 16'h0100; cur_bad = 1'b1; corrupt_arm = 1'b0;
          end
          if (early_arm && s_rcnt == 6) begin
            cur_early = 1'b1; cur_bad = 1'b1; early_arm = 1'b0;
          end
        end
      end
      awready = !aw_block;
      bvalid  = s_bpend;
      rvalid  = s_ractive;
      rlast   = s_ractive && ((s_rcnt == 7) || cur_early);
      rdata   = s_ractive ? (mem[((s_raddr + 2 * s_rcnt) % 4096) / 2] ^ cur_xor) : 16'h0;
    end
  end

  task automatic check_reset(input string when);
    check({when, "_awvalid"},  32'(awvalid),   32'd0);
    check({when, "_wvalid"},   32'(wvalid),    32'd0);
    check({when, "_wlast"},    32'(wlast),     32'd0);
    check({when, "_bready"},   32'(bready),    32'd0);
    check({when, "_arvalid"},  32'(arvalid),   32'd0);
    check({when, "_rready"},   32'(rready),    32'd0);
    check({when, "_awaddr"},   32'(awaddr),    32'd0);
    check({when, "_araddr"},   32'(araddr),    32'd0);
    check({when, "_wdata"},    32'(wdata),     32'd0);
    check({when, "_error"},    32'(error),     32'd0);
    check({when, "_errcnt"},   32'(error_cnt), 32'd0);
  endtask

  initial begin
    int k;
    int nw;
    rstn = 1'b0; aw_block = 1'b0; corrupt_arm = 1'b0; early_arm = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // Reset release: awvalid on the first clock, address 0, fixed lengths.
    rstn = 1'b1;
    @(negedge clk);
    check("first_awvalid", 32'(awvalid), 32'd1);
    check("first_awaddr",  32'(awaddr),  32'd0);
    check("awlen",         32'(awlen),   32'd7);
    check("arlen",         32'(arlen),   32'd7);

    // Whole write sweep: 256 bursts of 16 bytes, then reads start at 0.
    k = 0;
    while (!m_ar_seen && k < 20000) begin @(negedge clk); k++; end
    check("sweep1_to_read", 32'(m_ar_seen), 32'd1);
    check("sweep1_bursts", 32'(n_aw_sweep1), 32'd256);
    check("first_araddr", 32'(first_araddr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b20_wdata%0d", i), 32'(cap20_d[i]), 32'(exp20[i]));
      check($sformatf("b20_wlast%0d", i), 32'(cap20_l[i]), 32'(i == 7));
    end

    // Two full passes against the ideal memory: inverted data on pass 1, no errors.
    k = 0;
    while (m_sweeps < 3 && k < 20000) begin @(negedge clk); k++; end
    check("third_sweep_start", 32'(m_sweeps), 32'd3);
    check("pass1_beat26", 32'(cap26), 32'hFFD9);
    check("ideal_errcnt", 32'(error_cnt), 32'd0);
    check("ideal_pulses", 32'(n_err_pulses), 32'd0);

    // One corrupted read beat.
    corrupt_arm = 1'b1;
    k = 0;
    while (n_err_pulses < 1 && k < 10000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check("corrupt_pulses", 32'(n_err_pulses), 32'd1);
    check("corrupt_errcnt", 32'(error_cnt), 32'd1);

    // rlast on beat 6: counted as an error and the burst ends there.
    early_arm = 1'b1;
    k = 0;
    while (n_err_pulses < 2 && k < 1000) begin @(negedge clk); k++; end
    repeat (40) @(negedge clk);
    check("early_pulses", 32'(n_err_pulses), 32'd2);
    check("early_errcnt", 32'(error_cnt), 32'd2);
    check("early_exit_seen", 32'(exit_seen), 32'd1);

    // Reset in the middle of a write burst, then awready held low.
    k = 0;
    while (!(wvalid && m_wbeat == 3) && k < 10000) begin @(negedge clk); k++; end
    check("mid_burst_found", 32'(wvalid), 32'd1);
    rstn = 1'b0; aw_block = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_awvalid", 32'(awvalid), 32'd1);
      check("stall_awaddr",  32'(awaddr),  32'd0);
    end
    nw = n_w_total;
    aw_block = 1'b0;
    k = 0;
    while (n_w_total == nw && k < 50) begin @(negedge clk); k++; end
    check("post_stall_write", 32'(n_w_total - nw), 32'd1);
    check("post_stall_sweep", 32'(m_sweeps), 32'd1);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
